// File: rtl/tx_serialize.sv
// Dibit transmit serializer: one-word holding buffer, MSB-first dibit frame,
// optional zero padding, then an enforced inter-frame gap.
module tx_serialize #(
  parameter int unsigned PAD_DIBITS = 0,
  parameter int unsigned GAP_CYCLES = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [31:0] axiid,
  output logic        axiir,
  output logic        axiov,
  output logic [1:0]  axiod,
  output logic        axiol
);

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned DCNT_W = 5;
  localparam int unsigned DIBITS = 16;

  localparam logic [DCNT_W-1:0] DATA_N    = DCNT_W'(DIBITS);
  localparam logic [DCNT_W-1:0] DATA_LAST = DCNT_W'(DIBITS - 1);
  localparam logic [CNT_W-1:0]  PAD_N     = CNT_W'(PAD_DIBITS);
  localparam logic [CNT_W-1:0]  PAD_LAST  = CNT_W'(PAD_DIBITS - 1);
  localparam logic [CNT_W-1:0]  GAP_N     = CNT_W'(GAP_CYCLES);
  localparam logic              PAD_EN    = 1'(PAD_DIBITS != 0);

  typedef enum logic [1:0] {IDLE, SEND, PAD, GAP} state_t;

  state_t              state;
  logic [31:0]         pend;
  logic                pend_v;
  logic [31:0]         sr;
  logic [DCNT_W-1:0]   dcnt;
  logic [CNT_W-1:0]    pcnt;
  logic [CNT_W-1:0]    gcnt;
  logic                accept;
  logic                load;

  // A new frame starts from IDLE, or on the very edge the gap expires.
  assign accept = axiiv && axiir;
  assign load   = pend_v && ((state == IDLE) || ((state == GAP) && (gcnt == GAP_N)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pend   <= '0;
      pend_v <= 1'b0;
      sr     <= '0;
      dcnt   <= '0;
      pcnt   <= '0;
      gcnt   <= '0;
      axiir  <= 1'b1;
      axiov  <= 1'b0;
      axiod  <= 2'b00;
      axiol  <= 1'b0;
    end else begin
      // Holding buffer: accept and load can never coincide since accept needs it empty.
      if (accept) begin
        pend   <= axiid;
        pend_v <= 1'b1;
        axiir  <= 1'b0;
      end else if (load) begin
        pend_v <= 1'b0;
        axiir  <= 1'b1;
      end

      if (load) begin
        state <= SEND;
        sr    <= {pend[29:0], 2'b00};
        axiov <= 1'b1;
        axiod <= pend[31:30];
        axiol <= 1'b0;
        dcnt  <= DCNT_W'(1);
      end else begin
        unique case (state)
          IDLE: begin
            axiov <= 1'b0;
            axiod <= 2'b00;
            axiol <= 1'b0;
          end
          SEND: begin
            if (dcnt == DATA_N) begin
              if (PAD_EN) begin
                state <= PAD;
                axiod <= 2'b00;
                axiol <= (PAD_N == CNT_W'(1));
                pcnt  <= CNT_W'(1);
              end else begin
                state <= GAP;
                axiov <= 1'b0;
                axiod <= 2'b00;
                axiol <= 1'b0;
                gcnt  <= CNT_W'(1);
              end
            end else begin
              axiod <= sr[31:30];
              sr    <= {sr[29:0], 2'b00};
              dcnt  <= dcnt + DCNT_W'(1);
              axiol <= !PAD_EN && (dcnt == DATA_LAST);
            end
          end
          PAD: begin
            if (pcnt == PAD_N) begin
              state <= GAP;
              axiov <= 1'b0;
              axiod <= 2'b00;
              axiol <= 1'b0;
              gcnt  <= CNT_W'(1);
            end else begin
              pcnt  <= pcnt + CNT_W'(1);
              axiol <= (pcnt == PAD_LAST);
            end
          end
          GAP: begin
            if (gcnt == GAP_N) begin
              state <= IDLE;
            end else begin
              gcnt <= gcnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_serialize.sv
// Bench for tx_serialize: two instances (no padding / 16 pad dibits) checked
// every cycle against a frame-timing model, plus directed frame vectors.
module tb_tx_serialize;

  localparam int GAP  = 48;
  localparam int PAD1 = 16;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       iv;
  logic [1:0][31:0] id;
  logic [1:0]       ir;
  logic [1:0]       ov;
  logic [1:0][1:0]  od;
  logic [1:0]       ol;

  always #10 clk = ~clk;

  tx_serialize #(.PAD_DIBITS(0), .GAP_CYCLES(GAP)) dut0 (
    .clk(clk), .rst(rst), .axiiv(iv[0]), .axiid(id[0]), .axiir(ir[0]),
    .axiov(ov[0]), .axiod(od[0]), .axiol(ol[0]));

  tx_serialize #(.PAD_DIBITS(PAD1), .GAP_CYCLES(GAP)) dut1 (
    .clk(clk), .rst(rst), .axiiv(iv[1]), .axiid(id[1]), .axiir(ir[1]),
    .axiov(ov[1]), .axiod(od[1]), .axiol(ol[1]));

  typedef struct {
    int          fst;
    int          fend;
    int          len;
    int          last_idx;
    int          nlast;
    logic [63:0] data;
  } frame_t;

  typedef struct {
    int          sel;
    logic [31:0] word;
    logic [63:0] exp_data;
    int          exp_len;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: when each word was loaded and when the next load may happen.
  int          m_free [2];
  int          m_load [2];
  bit          m_pv   [2];
  logic [31:0] m_pend [2];
  logic [31:0] m_word [2];

  frame_t      cur [2];
  bit          in_fr [2];
  frame_t      q0[$];
  frame_t      q1[$];
  int          rx_cnt;
  logic [31:0] rx_sr;
  logic [31:0] rxq[$];

  function automatic int pad_of(int i);
    return (i == 0) ? 0 : PAD1;
  endfunction

  task automatic fail_now(string name, int got, int want);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, got, want);
  endtask

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  task automatic model_step(int i);
    bit acc, ld;
    if (rst) begin
      m_pv[i]   = 1'b0;
      m_load[i] = -1000;
      m_free[i] = cyc + 1;
    end else begin
      acc = iv[i] && !m_pv[i];
      ld  = m_pv[i] && (cyc >= m_free[i]);
      if (ld) begin
        m_word[i] = m_pend[i];
        m_load[i] = cyc;
        m_free[i] = cyc + 16 + pad_of(i) + GAP;
        m_pv[i]   = 1'b0;
      end
      if (acc) begin
        m_pend[i] = id[i];
        m_pv[i]   = 1'b1;
      end
    end
  endtask

  // Expected {axiov, axiod, axiol, axiir} after the current edge.
  function automatic logic [4:0] expect_out(int i);
    int k = cyc - m_load[i];
    int p = pad_of(i);
    logic       v = 1'b0;
    logic [1:0] d = 2'b00;
    logic       l = 1'b0;
    if (k >= 0 && k < 16) begin
      v = 1'b1;
      d = 2'(m_word[i] >> (30 - 2 * k));
      l = (k == 15) && (p == 0);
    end else if (k >= 16 && k < 16 + p) begin
      v = 1'b1;
      l = (k == 15 + p);
    end
    return {v, d, l, !m_pv[i]};
  endfunction

  task automatic capture(int i);
    if (ov[i]) begin
      if (!in_fr[i]) begin
        in_fr[i]        = 1'b1;
        cur[i].fst      = cyc;
        cur[i].len      = 0;
        cur[i].last_idx = -1;
        cur[i].nlast    = 0;
        cur[i].data     = '0;
      end
      cur[i].data = {cur[i].data[61:0], od[i]};
      if (ol[i]) begin
        cur[i].last_idx = cur[i].len;
        cur[i].nlast++;
      end
      cur[i].len++;
      if (i == 1 && rx_cnt < 16) begin
        rx_sr = {rx_sr[29:0], od[i]};
        rx_cnt++;
        if (rx_cnt == 16) rxq.push_back(rx_sr);
      end
    end else begin
      if (i == 1) rx_cnt = 0;
      if (in_fr[i]) begin
        in_fr[i]    = 1'b0;
        cur[i].fend = cyc - 1;
        if (i == 0) q0.push_back(cur[i]);
        else        q1.push_back(cur[i]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("cycle_dut%0d", i), 64'({ov[i], od[i], ol[i], ir[i]}), 64'(expect_out(i)));
      capture(i);
    end
  endtask

  task automatic send(int i, logic [31:0] w, output int acc);
    acc   = -1;
    iv[i] = 1'b1;
    id[i] = w;
    for (int n = 0; n < 400; n++) begin
      if (ir[i]) begin
        tick();
        acc = cyc;
        break;
      end
      tick();
    end
    iv[i] = 1'b0;
    if (acc < 0) fail_now("accept_timeout", acc, 0);
  endtask

  task automatic wait_frame(int i, output frame_t f);
    f = '{fst: -1, fend: -1, len: 0, last_idx: -1, nlast: 0, data: '0};
    for (int n = 0; n < 600; n++) begin
      if (i == 0 && q0.size() > 0) begin f = q0.pop_front(); return; end
      if (i == 1 && q1.size() > 0) begin f = q1.pop_front(); return; end
      tick();
    end
    fail_now("frame_timeout", 0, 1);
  endtask

  task automatic settle();
    iv = '0;
    repeat (150) tick();
    q0.delete();
    q1.delete();
    rxq.delete();
  endtask

  vec_t        vecs [5];
  frame_t      f, f1, f2, f3;
  int          acc, acc2, nv;
  logic [31:0] held;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{sel: 0, word: 32'hDEADBEEF, exp_data: 64'h0000_0000_DEAD_BEEF, exp_len: 16};
    vecs[1] = '{sel: 1, word: 32'h12345678, exp_data: 64'h1234_5678_0000_0000, exp_len: 32};
    vecs[2] = '{sel: 0, word: 32'h00000001, exp_data: 64'h0000_0000_0000_0001, exp_len: 16};
    vecs[3] = '{sel: 1, word: 32'hFFFFFFFF, exp_data: 64'hFFFF_FFFF_0000_0000, exp_len: 32};
    vecs[4] = '{sel: 0, word: 32'h80000003, exp_data: 64'h0000_0000_8000_0003, exp_len: 16};

    for (int i = 0; i < 2; i++) begin
      m_free[i] = 0; m_load[i] = -1000; m_pv[i] = 1'b0;
      m_pend[i] = '0; m_word[i] = '0; in_fr[i] = 1'b0;
    end
    rx_cnt = 0;
    rx_sr  = '0;
    iv     = '0;
    id     = '0;
    rst    = 1'b1;
    repeat (3) tick();
    check("reset_outputs_dut0", 64'({ov[0], od[0], ol[0], ir[0]}), 64'h1);
    check("reset_outputs_dut1", 64'({ov[1], od[1], ol[1], ir[1]}), 64'h1);
    rst = 1'b0;
    settle();

    // Single-frame vectors: contents, length, last marker, load latency.
    for (int v = 0; v < 5; v++) begin
      send(vecs[v].sel, vecs[v].word, acc);
      wait_frame(vecs[v].sel, f);
      check($sformatf("vec%0d_data", v), f.data, vecs[v].exp_data);
      check($sformatf("vec%0d_len", v), 64'(f.len), 64'(vecs[v].exp_len));
      check($sformatf("vec%0d_last_idx", v), 64'(f.last_idx), 64'(vecs[v].exp_len - 1));
      check($sformatf("vec%0d_last_count", v), 64'(f.nlast), 64'd1);
      check($sformatf("vec%0d_latency", v), 64'(f.fst - acc), 64'd1);
      settle();
    end

    // Back-to-back: second word accepted mid-frame, exact gap between frames.
    send(0, 32'h00000001, acc);
    send(0, 32'hFFFFFFFF, acc2);
    check("b2b_ready_low", 64'(ir[0]), 64'd0);
    wait_frame(0, f1);
    wait_frame(0, f2);
    check("b2b_accept_in_frame", 64'(acc2 <= f1.fend && acc2 >= f1.fst), 64'd1);
    check("b2b_frame1", f1.data, 64'h1);
    check("b2b_frame2", f2.data, 64'hFFFF_FFFF);
    check("b2b_gap", 64'(f2.fst - f1.fend - 1), 64'(GAP));
    settle();

    // Loopback through a receive-side aggregator model on the padded instance.
    send(1, 32'hCAFEF00D, acc);
    send(1, 32'h0BADBEEF, acc);
    for (int n = 0; n < 400 && rxq.size() < 2; n++) tick();
    if (rxq.size() < 2) fail_now("loopback_count", rxq.size(), 2);
    else begin
      check("loopback_word0", 64'(rxq[0]), 64'hCAFEF00D);
      check("loopback_word1", 64'(rxq[1]), 64'h0BADBEEF);
    end
    settle();

    // Reset on dibit 7 with a word pending.
    send(0, 32'h3C3C3C3C, acc);
    send(0, 32'h77777777, acc);
    for (int n = 0; n < 100 && !(in_fr[0] && cur[0].len == 8); n++) tick();
    check("rst_reached_dibit7", 64'(cur[0].len), 64'd8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_axiov", 64'(ov[0]), 64'd0);
    check("rst_axiol", 64'(ol[0]), 64'd0);
    check("rst_axiir", 64'(ir[0]), 64'd1);
    q0.delete();
    nv = 0;
    for (int n = 0; n < 80; n++) begin
      tick();
      if (ov[0]) nv++;
    end
    check("rst_no_resume", 64'(nv), 64'd0);
    send(0, 32'hA5A5A5A5, acc);
    wait_frame(0, f);
    check("rst_new_word", f.data, 64'hA5A5_A5A5);
    check("rst_new_len", 64'(f.len), 64'd16);
    settle();

    // Hold: axiid changes every cycle while ready is low; only the accepting edge counts.
    send(0, 32'h11111111, acc);
    send(0, 32'h22222222, acc);
    held  = '0;
    iv[0] = 1'b1;
    for (int n = 0; n < 300; n++) begin
      id[0] = $urandom;
      if (ir[0]) begin
        held = id[0];
        tick();
        break;
      end
      tick();
    end
    iv[0] = 1'b0;
    id[0] = $urandom;
    wait_frame(0, f1);
    wait_frame(0, f2);
    wait_frame(0, f3);
    check("hold_frame2", f2.data, 64'h2222_2222);
    check("hold_frame3", f3.data, 64'(held));
    settle();

    // Randomized traffic with occasional resets; every cycle checked by the model.
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 2; i++) begin
        iv[i] = ($urandom_range(0, 3) != 0);
        id[i] = $urandom;
      end
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
